// File: rtl/klingon_seg_rx.sv
// Klingon 7-segment receiver: sync + glitch filter + decode to BCD on a valid/ready slot.
// Latency STABLE_CYCLES+2 edges from first stable sample; a full, non-draining slot drops new digits (overrun).
module klingon_seg_rx #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       seg_in,
  output logic [3:0]       digit,
  output logic             digit_valid,
  input  logic             digit_ready,
  output logic             bad_pattern,
  output logic             overrun,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] ACC_AT  = CNT_W'(STABLE_CYCLES - 1);

  localparam logic [0:0] SLOT_EMPTY = 1'b0;
  localparam logic [0:0] SLOT_FULL  = 1'b1;

  logic [6:0]       s1, s2, segD, lastAcc;
  logic [CNT_W-1:0] cnt;
  logic [0:0]       slotState, slotNext;
  logic [3:0]       code;
  logic             isDigit, isBlank, isBad;
  logic             stable, accept, newPat, drain, loadDigit;

  always_comb begin
    code    = 4'd0;
    isDigit = 1'b1;
    isBlank = 1'b0;
    case (s2)
      7'h7E:   code = 4'd0;
      7'h40:   code = 4'd1;
      7'h41:   code = 4'd2;
      7'h49:   code = 4'd3;
      7'h23:   code = 4'd4;
      7'h1D:   code = 4'd5;
      7'h25:   code = 4'd6;
      7'h13:   code = 4'd7;
      7'h36:   code = 4'd8;
      7'h37:   code = 4'd9;
      7'h00: begin
        isDigit = 1'b0;
        isBlank = 1'b1;
      end
      default: isDigit = 1'b0;
    endcase
  end

  assign isBad  = !isDigit && !isBlank;
  assign stable = (s2 == segD);
  // cnt saturates past ACC_AT, so a long stable period accepts only once.
  assign accept = stable && (cnt == ACC_AT);
  assign newPat = accept && (s2 != lastAcc);

  assign digit_valid = (slotState == SLOT_FULL);
  assign drain       = digit_valid && digit_ready;
  assign loadDigit   = newPat && isDigit && (!digit_valid || drain);

  always_comb begin
    slotNext = slotState;
    if (loadDigit)  slotNext = SLOT_FULL;
    else if (drain) slotNext = SLOT_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= 7'h00;
      s2      <= 7'h00;
      segD    <= 7'h00;
      cnt     <= '0;
      lastAcc <= 7'h00;
    end else begin
      s1   <= seg_in;
      s2   <= s1;
      segD <= s2;
      if (!stable)              cnt <= '0;
      else if (cnt != CNT_MAX)  cnt <= cnt + 1'b1;
      if (newPat) lastAcc <= s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slotState   <= SLOT_EMPTY;
      digit       <= 4'd0;
      bad_pattern <= 1'b0;
      overrun     <= 1'b0;
      err_cnt     <= '0;
    end else begin
      slotState   <= slotNext;
      bad_pattern <= newPat && isBad;
      overrun     <= newPat && isDigit && digit_valid && !drain;
      if (loadDigit) digit <= code;
      if (newPat && isBad && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule
